// File: rtl/fre_meter_mc.sv
// ============================================================================
// Module   : fre_meter_mc
// Brief    : Multi-channel frequency meter with a shared decade-selectable gate
//            window, per-channel saturating counters and a result select mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fre_meter_mc #(
  parameter  int CH       = 2,
  parameter  int CNT_W    = 24,
  parameter  int GATE_CYC = 50_000_000,
  localparam int SEL_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [1:0]            gate_sel_i,
  input  logic [CH-1:0]         sig_i,
  input  logic [SEL_W-1:0]      ch_sel_i,
  output logic [CH*CNT_W-1:0]   freq_o,
  output logic [CH-1:0]         ovf_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      mux_freq_o
);

  localparam int GW = $clog2(GATE_CYC + 1);

  localparam logic [GW-1:0] C_LEN0 = GW'(GATE_CYC);
  localparam logic [GW-1:0] C_LEN1 = GW'(GATE_CYC / 10);
  localparam logic [GW-1:0] C_LEN2 = GW'(GATE_CYC / 100);
  localparam logic [GW-1:0] C_LEN3 = GW'(GATE_CYC / 1000);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t                    r_state;
  logic [CH-1:0]             r_sync1;
  logic [CH-1:0]             r_sync2;
  logic [CH-1:0]             r_sync3;
  logic [CH-1:0]             r_edge;
  logic [GW-1:0]             r_gate_cnt;
  logic [GW-1:0]             r_gate_len;
  logic [CH-1:0][CNT_W-1:0]  r_cnt;
  logic [CH-1:0]             r_ovf;
  logic [CH*CNT_W-1:0]       r_freq;
  logic [CH-1:0]             r_ovf_out;
  logic                      r_done;
  logic [CNT_W-1:0]          r_mux;

  logic [GW-1:0]             w_sel_len;
  logic [GW-1:0]             w_cur_len;
  logic                      w_last;
  logic [CNT_W-1:0]          w_mux;

  always_comb begin
    w_sel_len = C_LEN0;
    case (gate_sel_i)
      2'b00:   w_sel_len = C_LEN0;
      2'b01:   w_sel_len = C_LEN1;
      2'b10:   w_sel_len = C_LEN2;
      default: w_sel_len = C_LEN3;
    endcase
  end

  // The first gate cycle uses the live selection so it takes effect immediately.
  assign w_cur_len = (r_gate_cnt == '0) ? w_sel_len : r_gate_len;
  assign w_last    = (r_gate_cnt == (w_cur_len - GW'(1)));

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_edge  <= '0;
    end else begin
      r_sync1 <= sig_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gate_cnt <= '0;
      r_gate_len <= '0;
      r_cnt      <= '0;
      r_ovf      <= '0;
      r_freq     <= '0;
      r_ovf_out  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_gate_cnt <= '0;
          r_cnt      <= '0;
          r_ovf      <= '0;
          if (en_i) begin
            r_state <= RUN;
          end
        end
        RUN, LATCH: begin
          if (!en_i) begin
            r_state    <= IDLE;
            r_gate_cnt <= '0;
            r_cnt      <= '0;
            r_ovf      <= '0;
          end else begin
            if (r_gate_cnt == '0) begin
              r_gate_len <= w_sel_len;
            end
            if (w_last) begin
              // The pulse arriving on the final cycle still belongs to this gate.
              for (int k = 0; k < CH; k++) begin
                if (r_edge[k] && (&r_cnt[k])) begin
                  r_freq[k*CNT_W +: CNT_W] <= '1;
                  r_ovf_out[k]             <= 1'b1;
                end else begin
                  r_freq[k*CNT_W +: CNT_W] <= r_cnt[k] + CNT_W'(r_edge[k]);
                  r_ovf_out[k]             <= r_ovf[k];
                end
              end
              r_cnt      <= '0;
              r_ovf      <= '0;
              r_gate_cnt <= '0;
              r_done     <= 1'b1;
              r_state    <= LATCH;
            end else begin
              for (int k = 0; k < CH; k++) begin
                if (r_edge[k]) begin
                  if (&r_cnt[k]) begin
                    r_ovf[k] <= 1'b1;
                  end else begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                  end
                end
              end
              r_gate_cnt <= r_gate_cnt + GW'(1);
              r_state    <= RUN;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Out-of-range selections fall back to channel 0.
  always_comb begin
    w_mux = r_freq[0 +: CNT_W];
    for (int k = 0; k < CH; k++) begin
      if (ch_sel_i == SEL_W'(k)) begin
        w_mux = r_freq[k*CNT_W +: CNT_W];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_mux <= '0;
    end else begin
      r_mux <= w_mux;
    end
  end

  assign freq_o     = r_freq;
  assign ovf_o      = r_ovf_out;
  assign done_o     = r_done;
  assign mux_freq_o = r_mux;

endmodule

`default_nettype wire

// File: tb/tb_fre_meter_mc.sv
// ============================================================================
// Module   : tb_fre_meter_mc
// Brief    : Self-checking bench for fre_meter_mc against a window-count model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fre_meter_mc;

  localparam int CH       = 3;
  localparam int CNT_W    = 6;
  localparam int GATE_CYC = 2000;
  localparam int SEL_W    = 2;
  localparam int MAXV     = (1 << CNT_W) - 1;
  localparam int HIST     = 16384;

  logic                 clk_i = 1'b0;
  logic                 rst;
  logic                 en_i;
  logic [1:0]           gate_sel_i;
  logic [CH-1:0]        sig_i;
  logic [SEL_W-1:0]     ch_sel_i;
  logic [CH*CNT_W-1:0]  freq_o;
  logic [CH-1:0]        ovf_o;
  logic                 done_o;
  logic [CNT_W-1:0]     mux_freq_o;

  fre_meter_mc #(.CH(CH), .CNT_W(CNT_W), .GATE_CYC(GATE_CYC)) dut (
    .clk_i      (clk_i),
    .rst        (rst),
    .en_i       (en_i),
    .gate_sel_i (gate_sel_i),
    .sig_i      (sig_i),
    .ch_sel_i   (ch_sel_i),
    .freq_o     (freq_o),
    .ovf_o      (ovf_o),
    .done_o     (done_o),
    .mux_freq_o (mux_freq_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Stimulus: hp>0 toggles every hp cycles, hp<0 random bit, hp==0 held low.
  int hp[CH];
  int tcnt[CH];

  // Model: a gate starting at edge S and ending at edge E reports the rising
  // edges of sig_i sampled at edges S-2 .. E-3.
  int            cyc = 0;
  int            cum[CH];
  int            cum_hist[CH][HIST];
  logic [CH-1:0] prev;
  bit            m_active;
  int            m_start, m_len;
  int            m_freq[CH];
  logic [CH-1:0] m_ovf;
  bit            m_done;
  int            m_mux;
  int            n_done = 0;

  function automatic int dec_len(input logic [1:0] s);
    case (s)
      2'b00:   return GATE_CYC;
      2'b01:   return GATE_CYC / 10;
      2'b10:   return GATE_CYC / 100;
      default: return GATE_CYC / 1000;
    endcase
  endfunction

  always @(posedge clk_i) begin
    if (rst) begin
      prev     = '0;
      m_active = 1'b0;
      m_done   = 1'b0;
      m_mux    = 0;
      m_ovf    = '0;
      for (int k = 0; k < CH; k++) m_freq[k] = 0;
    end else begin
      m_mux = (ch_sel_i < CH) ? m_freq[ch_sel_i] : m_freq[0];
      for (int k = 0; k < CH; k++) begin
        if (sig_i[k] && !prev[k]) cum[k]++;
        prev[k] = sig_i[k];
      end
      m_done = 1'b0;
      if (!en_i) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_start  = cyc;
      end else if (cyc == m_start + 1) begin
        m_len = dec_len(gate_sel_i);
      end else if (cyc == m_start + m_len) begin
        for (int k = 0; k < CH; k++) begin
          int raw;
          raw = cum_hist[k][(cyc - 3) % HIST] - cum_hist[k][(m_start - 3) % HIST];
          m_freq[k] = (raw > MAXV) ? MAXV : raw;
          m_ovf[k]  = (raw > MAXV);
        end
        m_done  = 1'b1;
        n_done++;
        m_start = cyc;
      end
    end
    for (int k = 0; k < CH; k++) cum_hist[k][cyc % HIST] = cum[k];
    cyc++;
  end

  always @(negedge clk_i) begin
    if (!rst) begin
      for (int k = 0; k < CH; k++) begin
        total++;
        assert (freq_o[k*CNT_W +: CNT_W] === CNT_W'(m_freq[k])) else begin
          bad++;
          $error("FAIL freq ch%0d cyc=%0d got=%0d exp=%0d", k, cyc,
                 freq_o[k*CNT_W +: CNT_W], m_freq[k]);
        end
      end
      total++;
      assert (ovf_o === m_ovf) else begin
        bad++;
        $error("FAIL ovf cyc=%0d got=%b exp=%b", cyc, ovf_o, m_ovf);
      end
      total++;
      assert (done_o === m_done) else begin
        bad++;
        $error("FAIL done cyc=%0d got=%b exp=%b", cyc, done_o, m_done);
      end
      total++;
      assert (mux_freq_o === CNT_W'(m_mux)) else begin
        bad++;
        $error("FAIL mux cyc=%0d got=%0d exp=%0d", cyc, mux_freq_o, m_mux);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      for (int k = 0; k < CH; k++) begin
        if (hp[k] > 0) begin
          tcnt[k]++;
          if (tcnt[k] >= hp[k]) begin
            sig_i[k] = ~sig_i[k];
            tcnt[k]  = 0;
          end
        end else if (hp[k] < 0) begin
          sig_i[k] = 1'($urandom % 2);
        end else begin
          sig_i[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_zero(input string tag);
    total++;
    assert (freq_o === '0 && ovf_o === '0 && done_o === 1'b0 && mux_freq_o === '0) else begin
      bad++;
      $error("FAIL %s got freq=%h ovf=%b done=%b mux=%0d exp all zero",
             tag, freq_o, ovf_o, done_o, mux_freq_o);
    end
  endtask

  initial begin
    rst        = 1'b1;
    en_i       = 1'b0;
    gate_sel_i = 2'b00;
    sig_i      = '0;
    ch_sel_i   = '0;
    prev       = '0;
    for (int k = 0; k < CH; k++) begin
      hp[k] = 0; tcnt[k] = 0; cum[k] = 0; m_freq[k] = 0;
    end
    step(3);
    check_zero("reset_state");
    rst = 1'b0;
    step(10);

    // Decade gate 200 cycles: ch0 periodic, ch1 random, ch2 idle.
    en_i = 1'b1; gate_sel_i = 2'b01;
    hp[0] = 5; hp[1] = -1; hp[2] = 0;
    step(700);

    // Selection change mid-gate applies from the next gate.
    gate_sel_i = 2'b10;
    step(300);

    // Full gate with ch0 toggling every cycle saturates the counter.
    gate_sel_i = 2'b00; hp[0] = 1;
    step(4500);

    // Shortest gate.
    gate_sel_i = 2'b11; hp[0] = 3; hp[2] = 7;
    step(100);

    // Abort mid-gate and restart.
    gate_sel_i = 2'b01; ch_sel_i = 2'd2;
    step(250);
    en_i = 1'b0;
    step(37);
    en_i = 1'b1;
    step(500);

    // Asynchronous reset mid-gate clears every output at once.
    ch_sel_i = 2'd1;
    step(123);
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      ch_sel_i = 2'($urandom % 4);
      step(50);
    end

    total++;
    assert (n_done >= 10) else begin
      bad++;
      $error("FAIL done_count got=%0d exp>=10", n_done);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
